// File: rtl/dual_port_ram.sv
// dual_port_ram: byte-writable port A, read-only port B, self-clearing after reset.
module dual_port_ram #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 8,
    parameter int MEMDEPTH   = 256,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [DWIDTH/8-1:0]   a_be,
    input  logic [AWIDTH-1:0]     a_addr,
    input  logic [DWIDTH-1:0]     a_wdata,
    output logic [DWIDTH-1:0]     a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_en,
    input  logic [AWIDTH-1:0]     b_addr,
    output logic [DWIDTH-1:0]     b_rdata,
    output logic                  b_rvalid
);
    localparam logic CLEAR = 1'b0;
    localparam logic READY = 1'b1;
    localparam logic [AWIDTH:0] DEPTH = (AWIDTH+1)'(MEMDEPTH);
    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(MEMDEPTH - 1);

    logic [DWIDTH-1:0] mem [MEMDEPTH];
    logic state;
    logic [AWIDTH-1:0] cnt;
    logic ready, a_in, b_in, a_rd, a_wr, b_rd, a_sv, b_sv;
    logic [DWIDTH-1:0] a_old, b_old, a_new, b_word, a_sd, b_sd;

    assign ready  = state == READY;
    assign busy   = !ready;
    assign a_in   = {1'b0, a_addr} < DEPTH;
    assign b_in   = {1'b0, b_addr} < DEPTH;
    assign a_rd   = ready && a_en && !a_we;
    assign a_wr   = ready && a_en && a_we && a_in;
    assign b_rd   = ready && b_en;
    assign a_old  = a_in ? mem[a_addr] : '0;
    assign b_old  = b_in ? mem[b_addr] : '0;
    // write-first forwarding: a_wr already implies the shared address is in range
    assign b_word = (RDW_MODE == 1 && a_wr && a_addr == b_addr) ? a_new : b_old;

    always_comb begin
        a_new = a_old;
        for (int k = 0; k < DWIDTH/8; k++)
            if (a_be[k]) a_new[8*k +: 8] = a_wdata[8*k +: 8];
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (!ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= READY;
        end

    always_ff @(posedge clk)
        if (!ready) mem[cnt] <= '0;
        else if (a_wr) mem[a_addr] <= a_new;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk or negedge reset)
                if (!reset) begin
                    a_sv <= 1'b0;
                    b_sv <= 1'b0;
                    a_sd <= '0;
                    b_sd <= '0;
                end else begin
                    a_sv <= a_rd;
                    b_sv <= b_rd;
                    a_sd <= a_old;
                    b_sd <= b_word;
                end
        end else begin : g_lat1
            assign a_sv = a_rd;
            assign b_sv = b_rd;
            assign a_sd = a_old;
            assign b_sd = b_word;
        end
    endgenerate

    // output stage holds rdata between results
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_sv;
            b_rvalid <= b_sv;
            if (a_sv) a_rdata <= a_sd;
            if (b_sv) b_rdata <= b_sd;
        end
endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: default instance plus a 200-word, latency-2, write-first instance on shared stimulus.
module tb_dual_port_ram;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a_en = 1'b0, a_we = 1'b0, b_en = 1'b0;
    logic [3:0] a_be = '0;
    logic [7:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0;
    logic busy1, a_rvalid1, b_rvalid1, busy2, a_rvalid2, b_rvalid2;
    logic [31:0] a_rdata1, b_rdata1, a_rdata2, b_rdata2;

    typedef struct {
        logic [31:0] d;
        int due;
    } exp_t;

    exp_t q[4][$];
    logic [31:0] m1[256];
    logic [31:0] m2[256];
    string nm[4] = '{"a1", "b1", "a2", "b2"};
    int checks = 0, failures = 0, cyc = 0;

    dual_port_ram u1 (
        .clk(clk), .reset(reset), .busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1)
    );

    dual_port_ram #(.MEMDEPTH(200), .RD_LATENCY(2), .RDW_MODE(1)) u2 (
        .clk(clk), .reset(reset), .busy(busy2),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata2), .b_rvalid(b_rvalid2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        merge = o;
        for (int k = 0; k < 4; k++)
            if (be[k]) merge[8*k +: 8] = w[8*k +: 8];
    endfunction

    always @(negedge clk) begin
        logic v[4];
        logic [31:0] d[4];
        exp_t e;
        v = '{a_rvalid1, b_rvalid1, a_rvalid2, b_rvalid2};
        d = '{a_rdata1, b_rdata1, a_rdata2, b_rdata2};
        if (reset) for (int p = 0; p < 4; p++) begin
            if (v[p]) begin
                checks++;
                assert (q[p].size() != 0) else begin
                    failures++;
                    $error("FAIL %s spurious rvalid got=1 exp=0", nm[p]);
                end
                if (q[p].size() != 0) begin
                    e = q[p].pop_front();
                    chk({nm[p], "_data"}, d[p], e.d);
                    chk({nm[p], "_cycle"}, cyc, e.due);
                end
            end else if (q[p].size() != 0) begin
                checks++;
                assert (q[p][0].due > cyc) else begin
                    failures++;
                    $error("FAIL %s missing rvalid got=0 exp=1 due=%0d", nm[p], q[p][0].due);
                    void'(q[p].pop_front());
                end
            end
        end
    end

    task automatic op(input logic ae, input logic we, input logic [3:0] be, input logic [7:0] aa,
                      input logic [31:0] wd, input logic ben, input logic [7:0] ba);
        logic [31:0] o1, n1, o2, n2, bv;
        a_en = ae; a_we = we; a_be = be; a_addr = aa; a_wdata = wd; b_en = ben; b_addr = ba;
        o1 = m1[aa];
        n1 = merge(o1, wd, be);
        o2 = aa < 200 ? m2[aa] : 32'h0;
        n2 = merge(o2, wd, be);
        if (ae && !we) begin
            q[0].push_back('{o1, cyc + 1});
            q[2].push_back('{o2, cyc + 2});
        end
        if (ben) begin
            q[1].push_back('{m1[ba], cyc + 1});
            bv = ba >= 200 ? 32'h0 : (ae && we && aa == ba) ? n2 : m2[ba];
            q[3].push_back('{bv, cyc + 2});
        end
        if (ae && we) begin
            m1[aa] = n1;
            if (aa < 200) m2[aa] = n2;
        end
        @(negedge clk);
        a_en = 1'b0;
        b_en = 1'b0;
    endtask

    task automatic drain();
        a_en = 1'b0;
        b_en = 1'b0;
        repeat (4) @(negedge clk);
        for (int p = 0; p < 4; p++) chk({nm[p], "_drained"}, q[p].size(), 0);
    endtask

    // called right after reset release; counts edges until each instance leaves CLEAR
    task automatic wait_clear();
        int n = 0, n2 = 0;
        while ((busy1 || busy2) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy2 && n2 == 0) n2 = n;
            if (n == 150) begin
                a_en = 1'b0;
                b_en = 1'b0;
            end
        end
        chk("busy_len1", n, 256);
        chk("busy_len2", n2, 200);
        for (int i = 0; i < 256; i++) begin
            m1[i] = '0;
            m2[i] = '0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] ra, rb;
        repeat (3) @(negedge clk);
        chk("rst_busy1", busy1, 1);
        chk("rst_busy2", busy2, 1);
        chk("rst_a_rdata1", a_rdata1, 0);
        chk("rst_b_rdata2", b_rdata2, 0);
        chk("rst_a_rvalid1", a_rvalid1, 0);
        chk("rst_b_rvalid2", b_rvalid2, 0);
        reset = 1'b1;
        wait_clear();

        op(1, 0, 4'h0, 8'h00, 0, 1, 8'hFF);
        op(1, 0, 4'h0, 8'hFF, 0, 1, 8'h00);
        drain();

        op(1, 1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 0);
        op(1, 1, 4'h5, 8'h10, 32'h11223344, 0, 0);
        op(1, 0, 4'h0, 8'h10, 0, 0, 0);
        drain();
        chk("be_merge1", a_rdata1, 32'hDE22BE44);
        chk("be_merge2", a_rdata2, 32'hDE22BE44);

        op(1, 1, 4'h0, 8'h10, 32'hFFFFFFFF, 0, 0);
        op(1, 0, 4'h0, 8'h10, 0, 1, 8'h10);
        drain();
        chk("be0_noop", a_rdata1, 32'hDE22BE44);
        chk("same_addr_b1", b_rdata1, 32'hDE22BE44);

        op(1, 1, 4'hF, 8'h20, 32'hCAFEF00D, 1, 8'h20);
        drain();
        chk("rdw_old", b_rdata1, 32'h0);
        chk("rdw_new", b_rdata2, 32'hCAFEF00D);

        op(1, 1, 4'hF, 8'h48, 32'hAAAA5555, 0, 0);
        op(1, 1, 4'hF, 8'hC8, 32'h12345678, 0, 0);
        op(1, 0, 4'h0, 8'hC8, 0, 1, 8'h48);
        drain();
        chk("oor_read2", a_rdata2, 32'h0);
        chk("inrange_read1", a_rdata1, 32'h12345678);
        chk("oor_keep48", b_rdata2, 32'hAAAA5555);

        for (int i = 0; i < 4; i++) op(1, 1, 4'hF, 8'(i), 32'(i + 1), 0, 0);
        for (int i = 0; i < 4; i++) op(1, 0, 4'h0, 8'(3 - i), 0, 1, 8'(i));
        drain();
        chk("b2b_last_b", b_rdata1, 32'h4);
        chk("b2b_last_a", a_rdata2, 32'h1);

        repeat (80) begin
            ra = 8'($urandom_range(0, 7) + ($urandom_range(0, 1) != 0 ? 196 : 0));
            rb = 8'($urandom_range(0, 7) + ($urandom_range(0, 1) != 0 ? 196 : 0));
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               ra, $urandom, 1'($urandom_range(0, 1)), rb);
        end
        drain();

        a_en = 1'b1; a_we = 1'b0; a_addr = 8'h10; b_en = 1'b1; b_addr = 8'h01;
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_en = 1'b0;
        b_en = 1'b0;
        for (int p = 0; p < 4; p++) q[p].delete();
        #1;
        chk("midread_a_rvalid1", a_rvalid1, 0);
        chk("midread_a_rdata1", a_rdata1, 0);
        chk("midread_busy1", busy1, 1);
        @(negedge clk);
        reset = 1'b1;
        a_en = 1'b1; a_we = 1'b0; a_addr = 8'h05; b_en = 1'b1; b_addr = 8'h06;
        repeat (100) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midclear_busy1", busy1, 1);
        chk("midclear_b_rdata1", b_rdata1, 0);
        a_we = 1'b1; a_be = 4'hF; a_wdata = 32'hFFFFFFFF;
        reset = 1'b1;
        wait_clear();

        for (int i = 0; i < 256; i++) op(1, 0, 4'h0, 8'(i), 0, 1, 8'(255 - i));
        drain();
        chk("final_a1", a_rdata1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
